fpu_issue_queue: RTL and testbench

Operand issue and result-capture shim wrapped around the multi-cycle FPU adder/subtractor. Accepts add/sub requests over a valid/ready handshake, queues them, and presents each to the FPU's operand inputs aligned to the FPU's fixed 5-cycle frame. Returns the FPU's `data_out`/`status_out` as tagged responses over a second valid/ready handshake. Sits between the request source and the FPU; the FPU itself is unchanged and free-running.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_sync_fifo.sv | 46 ++++
 rtl/fpu_issue_queue.sv | 105 ++++++++++
 tb/tb_fpu_issue_queue.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU frame constants, phase encoding and status codes.
package fpu_pkg;

    localparam int FPU_PERIOD = 5;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_DECODE_ALIGN,
        PH_ADD_SUB,
        PH_NORMALIZE,
        PH_FINALIZE
    } ph_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [3:0] STATUS_EXACT    = 4'b0001;
    localparam logic [3:0] STATUS_OVERFLOW = 4'b0010;

    function automatic ph_t next_ph(input ph_t p);
        return (p == ph_t'(FPU_PERIOD - 1)) ? PH_IDLE : ph_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// fpu_sync_fifo: single-clock FIFO with occupancy count; a pop frees room for a same-cycle push when full.
module fpu_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push_i,
    input  logic [W-1:0]            data_i,
    input  logic                    pop_i,
    output logic [W-1:0]            data_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != FULL) || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop)
                rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: queues add/sub requests, issues them on the FPU's 5-cycle frame and
// returns the FPU results as tagged responses.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fpu_op_a,
    output logic [31:0]      fpu_op_b,
    output logic             fpu_op_select,
    input  logic [31:0]      fpu_data,
    input  logic [3:0]       fpu_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [3:0]       rsp_status,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = 65 + TAG_W;
    localparam int SW = 36 + TAG_W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    ph_t              ph_q;
    logic             req_ready_q, v_issue_q, v_result_q, op_sel_q;
    logic [31:0]      op_a_q, op_b_q;
    logic [TAG_W-1:0] tag_issue_q, tag_result_q;
    logic [AW:0]      req_cnt, rsp_cnt, req_cnt_d;
    logic [AW+1:0]    rsp_used;
    logic [RW-1:0]    req_head;
    logic [SW-1:0]    rsp_head;
    logic             req_push, issue, capture, rsp_pop;

    assign req_push = req_valid && req_ready_q;
    assign rsp_pop  = rsp_valid && rsp_ready;
    // Responses already stored plus the one still in the FPU must leave room for this issue.
    assign rsp_used = (AW+2)'(rsp_cnt) + (AW+2)'(v_issue_q);
    assign issue    = (ph_q == PH_FINALIZE) && (req_cnt != '0) && (rsp_used < (AW+2)'(DEPTH));
    assign capture  = (ph_q == PH_IDLE) && v_result_q;
    assign req_cnt_d = req_cnt + (AW+1)'(req_push) - (AW+1)'(issue);

    fpu_sync_fifo #(.W(RW), .DEPTH(DEPTH)) u_req_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (req_push),
        .data_i  ({req_op, req_a, req_b, req_tag}),
        .pop_i   (issue),
        .data_o  (req_head),
        .count_o (req_cnt)
    );

    fpu_sync_fifo #(.W(SW), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (capture),
        .data_i  ({fpu_data, fpu_status, tag_result_q}),
        .pop_i   (rsp_pop),
        .data_o  (rsp_head),
        .count_o (rsp_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_q         <= PH_IDLE;
            req_ready_q  <= 1'b0;
            v_issue_q    <= 1'b0;
            v_result_q   <= 1'b0;
            op_sel_q     <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            tag_issue_q  <= '0;
            tag_result_q <= '0;
        end else begin
            ph_q        <= next_ph(ph_q);
            req_ready_q <= req_cnt_d != FULL;
            if (ph_q == PH_FINALIZE) begin
                v_issue_q    <= issue;
                v_result_q   <= v_issue_q;
                tag_result_q <= tag_issue_q;
                if (issue)
                    {op_sel_q, op_a_q, op_b_q, tag_issue_q} <= req_head;
            end else if (capture) begin
                v_result_q <= 1'b0;
            end
        end
    end

    assign req_ready     = req_ready_q;
    assign fpu_op_a      = op_a_q;
    assign fpu_op_b      = op_b_q;
    assign fpu_op_select = op_sel_q;
    assign rsp_valid     = rsp_cnt != '0;
    assign {rsp_data, rsp_status, rsp_tag} = rsp_head;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue: drives the issue queue against a frame-accurate FPU stand-in and
// checks every response against an in-order expectation queue.
module tb_fpu_issue_queue;
    import fpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk, reset_n;
    logic             req_valid, req_ready, req_op, fpu_op_select, rsp_valid, rsp_ready;
    logic [31:0]      req_a, req_b, fpu_op_a, fpu_op_b, fpu_data, rsp_data;
    logic [3:0]       fpu_status, rsp_status;
    logic [TAG_W-1:0] req_tag, rsp_tag;

    fpu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .req_tag       (req_tag),
        .fpu_op_a      (fpu_op_a),
        .fpu_op_b      (fpu_op_b),
        .fpu_op_select (fpu_op_select),
        .fpu_data      (fpu_data),
        .fpu_status    (fpu_status),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_status    (rsp_status),
        .rsp_tag       (rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  t;
    } exp_t;

    exp_t        exp_q[$];
    longint      rsp_cyc[$];
    int          n_cmp = 0, n_bad = 0;
    int          ph_m;
    longint      cyc;
    logic [31:0] s_a, s_b;
    logic        s_op, rnd_on;
    logic [35:0] mr;
    exp_t        me;
    longint      last_cyc;
    int          last_ph;

    // Stand-in FPU result: true IEEE values for the named vectors, a scrambled sum otherwise.
    function automatic logic [35:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (!op && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, STATUS_EXACT};
        if (op && a == 32'h40400000 && b == 32'h3F800000) return {32'h40000000, STATUS_EXACT};
        if (!op && a[30:23] == 8'hFE && b[30:23] == 8'hFE) return {32'h7F800000, STATUS_OVERFLOW};
        return {(a + (op ? -b : b)) ^ 32'h5A5A0000, STATUS_EXACT};
    endfunction

    // Free-running FPU: samples operands at the end of frame cycle 0, publishes at the end of cycle 4.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_m <= 0;
            s_a <= '0;
            s_b <= '0;
            s_op <= 1'b0;
            fpu_data <= '0;
            fpu_status <= '0;
        end else begin
            ph_m <= (ph_m == FPU_PERIOD - 1) ? 0 : ph_m + 1;
            if (ph_m == 0) {s_op, s_a, s_b} <= {fpu_op_select, fpu_op_a, fpu_op_b};
            if (ph_m == FPU_PERIOD - 1) {fpu_data, fpu_status} <= fpu_model(s_a, s_b, s_op);
        end
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard: accepted requests enqueue their expected response; every handshake must match the oldest.
    always @(negedge clk) begin
        if (reset_n) begin
            if (req_valid && req_ready) begin
                mr = fpu_model(req_a, req_b, req_op);
                exp_q.push_back('{d: mr[35:4], s: mr[3:0], t: req_tag});
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_unexpected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    me = exp_q.pop_front();
                    chk("rsp_payload", 64'({rsp_data, rsp_status, rsp_tag}), 64'(me));
                end
                rsp_cyc.push_back(cyc);
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [3:0] tag);
        int w;
        w = 0;
        req_a = a;
        req_b = b;
        req_op = op;
        req_tag = tag;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        last_cyc = cyc;
        last_ph = ph_m;
    endtask

    task automatic wait_rsp();
        int w;
        w = 0;
        @(negedge clk);
        while (!rsp_valid && w < 80) begin
            @(negedge clk);
            w++;
        end
        chk("rsp_wait", 64'(rsp_valid), 64'd1);
    endtask

    task automatic pop_one();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_bus"}, 64'({rsp_data, rsp_status, rsp_tag}), 64'd0);
        chk({tag, "_fpu_ops"}, {fpu_op_a, fpu_op_b} | 64'(fpu_op_select), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_op = 1'b0;
        req_tag = '0;
        rsp_ready = 1'b0;
        rnd_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req_ready_rise", 64'(req_ready), 64'd1);

        // Add: issue at the next frame end after acceptance, response visible 6 edges later.
        push(32'h3F800000, 32'h40000000, OP_ADD, 4'd3);
        k = ((4 - last_ph) + 5) % 5 + 1;
        repeat (k + 5) @(posedge clk);
        #1;
        chk("add_lat_early", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("add_lat", 64'(rsp_valid), 64'd1);
        chk("add_data", 64'(rsp_data), 64'h40400000);
        chk("add_status", 64'(rsp_status), 64'(STATUS_EXACT));
        chk("add_tag", 64'(rsp_tag), 64'd3);
        pop_one();

        push(32'h40400000, 32'h3F800000, OP_SUB, 4'd5);
        wait_rsp();
        chk("sub_data", 64'(rsp_data), 64'h40000000);
        chk("sub_status", 64'(rsp_status), 64'(STATUS_EXACT));
        chk("sub_tag", 64'(rsp_tag), 64'd5);
        pop_one();

        // Back-to-back with a willing consumer: one result every frame.
        rsp_ready = 1'b1;
        rsp_cyc.delete();
        for (int i = 0; i < 4; i++) push($urandom, $urandom, 1'($urandom), 4'(i));
        k = 0;
        while (rsp_cyc.size() < 4 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("b2b_count", 64'(rsp_cyc.size()), 64'd4);
        for (int i = 1; i < 4 && i < rsp_cyc.size(); i++)
            chk("b2b_gap", 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'd5);
        rsp_ready = 1'b0;

        // Backpressure: four results park in the response FIFO, four requests stay queued.
        for (int i = 0; i < 8; i++) push($urandom, $urandom, 1'($urandom), 4'(8 + i));
        repeat (40) @(posedge clk);
        #1;
        chk("bp_req_ready", 64'(req_ready), 64'd0);
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_head_tag", 64'(rsp_tag), 64'd8);
        chk("bp_pending", 64'(exp_q.size()), 64'd8);
        rsp_ready = 1'b1;
        drain("bp_drain");
        repeat (20) @(posedge clk);
        #1;
        chk("bp_no_dup", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;

        push(32'h7F000000, 32'h7F000000, OP_ADD, 4'd9);
        wait_rsp();
        chk("ovf_status", 64'(rsp_status), 64'(STATUS_OVERFLOW));
        chk("ovf_tag", 64'(rsp_tag), 64'd9);
        pop_one();

        // Reset two cycles into the frame of an issued operation.
        push(32'h12345678 | $urandom, 32'h00ABCDEF, OP_ADD, 4'd6);
        k = ((4 - last_ph) + 5) % 5 + 1;
        repeat (k + 2) @(posedge clk);
        #3;
        chk("rst_phase", 64'(ph_m), 64'd2);
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        push(32'h3F800000, 32'h40000000, OP_ADD, 4'd12);
        wait_rsp();
        chk("post_rst_data", 64'(rsp_data), 64'h40400000);
        chk("post_rst_tag", 64'(rsp_tag), 64'd12);
        pop_one();

        // Randomized traffic with a stuttering consumer.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    push($urandom, $urandom, 1'($urandom), 4'($urandom));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        drain("rnd_drain");
        rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
